sd_fifo_commit: RTL and testbench
=================================

# sd_fifo_commit

Synchronous srdy/drdy FIFO with independent transactional commit/abort on the write side and the read side. A producer can write a burst and then either publish it with a commit or discard it with an abort. A consumer can read speculatively and then either release the space with a commit or rewind with an abort for replay. It sits between sdlib srdy/drdy pipeline stages where packet-level accept/reject is needed.

## Interface
- width, 8: data word width in bits.
- depth, 16: storage entries; must be a power of two, at least 4; usable capacity is depth-1.
- rd_commit, 0: 1 = read-side commit/abort active; 0 = every read commits immediately and p_commit/p_abort are ignored.
- wr_commit, 0: 1 = write-side commit/abort active; 0 = every write commits immediately and c_commit/c_abort are ignored.
- asz, $clog2(depth): pointer width.
- usz, $clog2(depth+1): usage counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- c_srdy  in  1  producer has a valid word.
- c_drdy  out  1  FIFO can accept a word.
- c_commit  in  1  publish all words written since the last commit, including any word transferred this cycle.
- c_abort  in  1  discard all uncommitted written words.
- c_data  in  width  write data.
- c_usage  out  usz  entries occupied from the writer's view: wrptr - com_rdptr.
- p_srdy  out  1  committed word available to read.
- p_drdy  in  1  consumer accepts the word.
- p_commit  in  1  release all words read since the last commit, including any word transferred this cycle.
- p_abort  in  1  rewind the read pointer to the last read commit.
- p_data  out  width  read data at rdptr.
- p_usage  out  usz  committed words not yet read: com_wrptr - rdptr.

## Operation
- State consists of four asz-bit pointers, all wrapping modulo depth: wrptr, com_wrptr, rdptr, com_rdptr. Storage is a depth x width array.
- Full: (wrptr+1) mod depth == com_rdptr. Set c_drdy = !full.
- Empty: rdptr == com_wrptr. Set p_srdy = !empty.
- Write transfer (c_srdy & c_drdy): store mem[wrptr] = c_data, then wrptr++.
- Read transfer (p_srdy & p_drdy): rdptr++.
- Write commit, when wr_commit=1:
  - c_abort sets wrptr = com_wrptr.
  - Otherwise c_commit sets com_wrptr to the next value of wrptr.
  - Abort has priority over commit. A write in the same cycle as c_abort is discarded.
- Write commit, when wr_commit=0: com_wrptr tracks the next value of wrptr every cycle.
- Read commit, when rd_commit=1:
  - p_abort sets rdptr = com_rdptr.
  - Otherwise p_commit sets com_rdptr to the next value of rdptr.
  - Abort wins over commit. A read in the same cycle as p_abort is discarded.
- Read commit, when rd_commit=0: com_rdptr tracks the next value of rdptr.
- Uncommitted words are never visible on p_*. Space that has been read but not committed is never reusable on c_*.
- Reset sets all pointers to 0. Memory contents are not reset.

## Timing
- Reset output values: c_drdy=1, p_srdy=0, c_usage=0, p_usage=0. p_data is undefined.
- c_drdy, p_srdy, p_data and both usage outputs are combinational from registered pointers and memory only. None depends on same-cycle c_srdy, p_drdy, commit or abort inputs.
- p_data = mem[rdptr] with zero latency.
- Commit-to-visibility latency is 1 cycle. A word committed at edge N is offered on p_srdy after edge N.
- After a write abort at edge N, c_drdy reflects the restored wrptr after edge N.
- Wrap-around: all pointer arithmetic is modulo depth.
- Usage values are computed modulo depth and lie in the range 0..depth-1.
- Reset mid-burst discards all uncommitted and committed data.

## Configuration
- SD_FIFO_COMMIT_CHECK_EN:
  - When defined, simulation-only checks $display an error each cycle for:
    - a write attempted while full and dropped;
    - commit and abort asserted together on the same side;
    - c_usage > depth-1.
  - When undefined, none of these checks is compiled in.
  - Functional behaviour is identical either way.

## Test plan
- width=16, depth=32, wr_commit=1, rd_commit=1, c_commit and p_commit held at 1. Stream 64 sequential words, first with the consumer always ready, then with a 0xA5 drdy pattern, then 128 words with a 0x11 srdy pattern. Required: in-order output, no loss or duplication, no errors within 1600 cycles.
- c_commit=0: write 31 words. Required: c_drdy=0, p_srdy=0.
  - Then pulse c_abort for one cycle. Required: c_drdy=1 immediately after that edge, c_usage=0, and none of the aborted words ever appears on p_*.
- Write 30 words uncommitted, then a 31st word with c_commit=1. Required: all 31 words delivered in order.
- p_commit=0: fill with 31 words and read all 31. Required: p_srdy=0 and c_drdy=0 (writer still sees full).
- Continuing the previous case, pulse p_abort. Required: the same 31 words are re-read in order starting from the first.
  - Then assert p_commit while the last words are read. Required: c_drdy=1 and c_usage=0.
- Assert reset while the FIFO holds 10 uncommitted and 5 committed words. Required: p_srdy=0, c_drdy=1, and both usage outputs = 0 on the next cycle.

Source files
------------

// File: rtl/sd_fifo_commit.sv
// Synchronous srdy/drdy FIFO with independent write-side and read-side commit/abort.
// Optional simulation checks are enabled by defining SD_FIFO_COMMIT_CHECK_EN.
module sd_fifo_commit #(
   parameter int unsigned width     = 8,
   parameter int unsigned depth     = 16,
   parameter int unsigned rd_commit = 0,
   parameter int unsigned wr_commit = 0,
   parameter int unsigned asz       = $clog2(depth),
   parameter int unsigned usz       = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic             c_commit,
   input  logic             c_abort,
   input  logic [width-1:0] c_data,
   output logic [usz-1:0]   c_usage,
   output logic             p_srdy,
   input  logic             p_drdy,
   input  logic             p_commit,
   input  logic             p_abort,
   output logic [width-1:0] p_data,
   output logic [usz-1:0]   p_usage
);

   logic [asz-1:0]   wrptr_q, wrptr_d;
   logic [asz-1:0]   com_wrptr_q, com_wrptr_d;
   logic [asz-1:0]   rdptr_q, rdptr_d;
   logic [asz-1:0]   com_rdptr_q, com_rdptr_d;
   logic [width-1:0] mem [depth];

   logic             full, empty;
   logic             wr_xfer, rd_xfer, wr_en;
   logic [asz-1:0]   wr_used, rd_avail;

   // Writer sees space held by read-but-uncommitted words as occupied.
   assign full     = (wrptr_q + asz'(1)) == com_rdptr_q;
   assign empty    = rdptr_q == com_wrptr_q;
   assign c_drdy   = !full;
   assign p_srdy   = !empty;
   assign wr_xfer  = c_srdy & c_drdy;
   assign rd_xfer  = p_srdy & p_drdy;

   assign wr_used  = wrptr_q - com_rdptr_q;
   assign rd_avail = com_wrptr_q - rdptr_q;
   assign c_usage  = usz'(wr_used);
   assign p_usage  = usz'(rd_avail);
   assign p_data   = mem[rdptr_q];

   always_comb begin
      wrptr_d     = wrptr_q;
      com_wrptr_d = com_wrptr_q;
      wr_en       = 1'b0;
      if ((wr_commit != 0) && c_abort) begin
         wrptr_d = com_wrptr_q;
      end else begin
         if (wr_xfer) begin
            wr_en   = 1'b1;
            wrptr_d = wrptr_q + asz'(1);
         end
         if ((wr_commit == 0) || c_commit) begin
            com_wrptr_d = wrptr_d;
         end
      end
   end

   always_comb begin
      rdptr_d     = rdptr_q;
      com_rdptr_d = com_rdptr_q;
      if ((rd_commit != 0) && p_abort) begin
         rdptr_d = com_rdptr_q;
      end else begin
         if (rd_xfer) begin
            rdptr_d = rdptr_q + asz'(1);
         end
         if ((rd_commit == 0) || p_commit) begin
            com_rdptr_d = rdptr_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrptr_q     <= '0;
         com_wrptr_q <= '0;
         rdptr_q     <= '0;
         com_rdptr_q <= '0;
      end else begin
         wrptr_q     <= wrptr_d;
         com_wrptr_q <= com_wrptr_d;
         rdptr_q     <= rdptr_d;
         com_rdptr_q <= com_rdptr_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wrptr_q] <= c_data;
      end
   end

`ifdef SD_FIFO_COMMIT_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (c_srdy && full) begin
            $display("sd_fifo_commit error: write dropped while full at %0t", $time);
         end
         if (c_commit && c_abort) begin
            $display("sd_fifo_commit error: c_commit and c_abort together at %0t", $time);
         end
         if (p_commit && p_abort) begin
            $display("sd_fifo_commit error: p_commit and p_abort together at %0t", $time);
         end
         if (32'(c_usage) > depth - 1) begin
            $display("sd_fifo_commit error: c_usage %0d out of range at %0t", c_usage, $time);
         end
      end
   end
`else
   // Checks compiled out.
`endif

endmodule

// File: tb/tb_sd_fifo_commit.sv
// Self-checking bench for sd_fifo_commit: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sd_fifo_commit;

   localparam int W   = 16;
   localparam int D   = 32;
   localparam int USZ = $clog2(D + 1);

   logic           clk = 1'b0;
   logic           reset;
   logic           c_srdy, c_drdy, c_commit, c_abort;
   logic [W-1:0]   c_data;
   logic [USZ-1:0] c_usage;
   logic           p_srdy, p_drdy, p_commit, p_abort;
   logic [W-1:0]   p_data;
   logic [USZ-1:0] p_usage;

   always #5 clk = ~clk;

   sd_fifo_commit #(
      .width(W), .depth(D), .rd_commit(1), .wr_commit(1)
   ) dut (
      .clk(clk), .reset(reset),
      .c_srdy(c_srdy), .c_drdy(c_drdy), .c_commit(c_commit), .c_abort(c_abort),
      .c_data(c_data), .c_usage(c_usage),
      .p_srdy(p_srdy), .p_drdy(p_drdy), .p_commit(p_commit), .p_abort(p_abort),
      .p_data(p_data), .p_usage(p_usage)
   );

   int checks = 0;
   int errors = 0;
   int data_base = 16'h100;

   // Model: uncommitted writes, committed-unread words, read-but-uncommitted words.
   logic [W-1:0] q_wr[$];
   logic [W-1:0] q_av[$];
   logic [W-1:0] q_rd[$];

   logic         dut_rx;
   logic [W-1:0] dut_rx_data;

   typedef struct {
      logic         cs, cc, ca;
      logic [W-1:0] cd;
      logic         pd, pc, pa;
      logic         ex_cdrdy, ex_psrdy;
      int           ex_cu, ex_pu;
      logic [W-1:0] ex_pd;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      c_srdy = 0; c_commit = 0; c_abort = 0; c_data = '0;
      p_drdy = 0; p_commit = 0; p_abort = 0; reset = 0;
   endtask

   task automatic model_check();
      int occ;
      occ = q_wr.size() + q_av.size() + q_rd.size();
      check("model_c_drdy", 32'(c_drdy), 32'(occ < D - 1));
      check("model_p_srdy", 32'(p_srdy), 32'(q_av.size() > 0));
      check("model_c_usage", 32'(c_usage), 32'(occ));
      check("model_p_usage", 32'(p_usage), 32'(q_av.size()));
      if (q_av.size() > 0) check("model_p_data", 32'(p_data), 32'(q_av[0]));
   endtask

   // Inputs are already applied; check outputs, advance model, cross one edge.
   task automatic step();
      int occ;
      logic wx, rx;
      model_check();
      dut_rx      = p_srdy && p_drdy && !p_abort && !reset;
      dut_rx_data = p_data;
      if (reset) begin
         q_wr.delete(); q_av.delete(); q_rd.delete();
      end else begin
         occ = q_wr.size() + q_av.size() + q_rd.size();
         wx  = c_srdy && (occ < D - 1);
         rx  = p_drdy && (q_av.size() > 0);
         if (p_abort) begin
            for (int i = q_rd.size() - 1; i >= 0; i--) q_av.push_front(q_rd[i]);
            q_rd.delete();
         end else begin
            if (rx) q_rd.push_back(q_av.pop_front());
            if (p_commit) q_rd.delete();
         end
         if (c_abort) begin
            q_wr.delete();
         end else begin
            if (wx) q_wr.push_back(c_data);
            if (c_commit) begin
               foreach (q_wr[i]) q_av.push_back(q_wr[i]);
               q_wr.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_stream(input int n, input logic [7:0] spat, input logic [7:0] dpat,
                             input int budget);
      int sent = 0, got = 0, cyc = 0;
      logic acc;
      idle();
      c_commit = 1; p_commit = 1;
      while (got < n && cyc < budget) begin
         c_srdy = spat[cyc % 8] && (sent < n);
         c_data = W'(data_base + sent);
         p_drdy = dpat[cyc % 8];
         acc    = c_srdy && c_drdy;
         step();
         if (dut_rx) begin
            check("stream_order", 32'(dut_rx_data), 32'(W'(data_base + got)));
            got++;
         end
         if (acc) sent++;
         cyc++;
      end
      check("stream_count", 32'(got), 32'(n));
      data_base += n;
      idle();
   endtask

   initial begin
      int got, cyc;
      idle();
      reset = 1;
      @(posedge clk); @(posedge clk); #1;
      reset = 0;

      check("reset_c_drdy", 32'(c_drdy), 32'd1);
      check("reset_p_srdy", 32'(p_srdy), 32'd0);
      check("reset_c_usage", 32'(c_usage), 32'd0);
      check("reset_p_usage", 32'(p_usage), 32'd0);

      //           cs cc ca  cd        pd pc pa  cdrdy psrdy cu pu  pd
      vecs[0]  = '{1, 0, 0, 16'h00A1, 0, 0, 0, 1, 0, 1, 0, 16'h0000};
      vecs[1]  = '{1, 1, 0, 16'h00A2, 0, 0, 0, 1, 1, 2, 2, 16'h00A1};
      vecs[2]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 1, 2, 1, 16'h00A2};
      vecs[3]  = '{0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 2, 2, 16'h00A1};
      vecs[4]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 1, 1, 1, 1, 16'h00A2};
      vecs[5]  = '{1, 0, 1, 16'h00A3, 0, 0, 0, 1, 1, 1, 1, 16'h00A2};
      vecs[6]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 0, 16'h0000};
      vecs[7]  = '{1, 1, 1, 16'h00A4, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
      vecs[8]  = '{1, 0, 0, 16'h00A5, 1, 0, 0, 1, 0, 1, 0, 16'h0000};
      vecs[9]  = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 16'h00A5};
      vecs[10] = '{0, 0, 0, 16'h0000, 1, 1, 1, 1, 1, 1, 1, 16'h00A5};
      vecs[11] = '{0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 0, 16'h0000};

      foreach (vecs[i]) begin
         c_srdy = vecs[i].cs; c_commit = vecs[i].cc; c_abort = vecs[i].ca;
         c_data = vecs[i].cd;
         p_drdy = vecs[i].pd; p_commit = vecs[i].pc; p_abort = vecs[i].pa;
         step();
         check("vec_c_drdy", 32'(c_drdy), 32'(vecs[i].ex_cdrdy));
         check("vec_p_srdy", 32'(p_srdy), 32'(vecs[i].ex_psrdy));
         check("vec_c_usage", 32'(c_usage), 32'(vecs[i].ex_cu));
         check("vec_p_usage", 32'(p_usage), 32'(vecs[i].ex_pu));
         if (vecs[i].ex_psrdy) check("vec_p_data", 32'(p_data), 32'(vecs[i].ex_pd));
      end
      idle();

      run_stream(64, 8'hFF, 8'hFF, 700);
      run_stream(64, 8'hFF, 8'hA5, 700);
      run_stream(128, 8'h11, 8'hFF, 700);

      // Fill uncommitted, then abort: nothing may leak to the reader.
      idle();
      p_drdy = 1;
      for (int i = 0; i < 31; i++) begin
         c_srdy = 1; c_data = W'(16'hDEAD + i);
         step();
      end
      c_srdy = 0;
      check("wabort_full_c_drdy", 32'(c_drdy), 32'd0);
      check("wabort_full_p_srdy", 32'(p_srdy), 32'd0);
      c_abort = 1;
      step();
      c_abort = 0;
      check("wabort_c_drdy", 32'(c_drdy), 32'd1);
      check("wabort_c_usage", 32'(c_usage), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("wabort_no_leak", 32'(dut_rx), 32'd0);
      end
      idle();

      // 30 uncommitted words published by a commit on the 31st.
      for (int i = 0; i < 31; i++) begin
         c_srdy = 1; c_commit = (i == 30); c_data = W'(data_base + i);
         step();
      end
      idle();
      p_drdy = 1; p_commit = 1;
      got = 0; cyc = 0;
      while (got < 31 && cyc < 60) begin
         step();
         if (dut_rx) begin
            check("late_commit_order", 32'(dut_rx_data), 32'(W'(data_base + got)));
            got++;
         end
         cyc++;
      end
      check("late_commit_count", 32'(got), 32'd31);
      data_base += 31;
      idle();

      // Speculative read of a full FIFO, rewind, replay, then release.
      c_commit = 1;
      for (int i = 0; i < 31; i++) begin
         c_srdy = 1; c_data = W'(data_base + i);
         step();
      end
      c_srdy = 0;
      p_drdy = 1;
      got = 0; cyc = 0;
      while (got < 31 && cyc < 40) begin
         step();
         if (dut_rx) begin
            check("spec_read_order", 32'(dut_rx_data), 32'(W'(data_base + got)));
            got++;
         end
         cyc++;
      end
      p_drdy = 0;
      check("spec_read_count", 32'(got), 32'd31);
      check("spec_read_p_srdy", 32'(p_srdy), 32'd0);
      check("spec_read_c_drdy", 32'(c_drdy), 32'd0);
      p_abort = 1;
      step();
      p_abort = 0;
      got = 0; cyc = 0;
      while (got < 31 && cyc < 40) begin
         p_drdy = 1; p_commit = (got == 30);
         step();
         if (dut_rx) begin
            check("replay_order", 32'(dut_rx_data), 32'(W'(data_base + got)));
            got++;
         end
         cyc++;
      end
      idle();
      check("replay_count", 32'(got), 32'd31);
      check("release_c_drdy", 32'(c_drdy), 32'd1);
      check("release_c_usage", 32'(c_usage), 32'd0);
      data_base += 31;

      // Reset with 5 committed and 10 uncommitted words held.
      for (int i = 0; i < 15; i++) begin
         c_srdy = 1; c_commit = (i < 5); c_data = W'(16'hBEEF + i);
         step();
      end
      idle();
      check("pre_reset_c_usage", 32'(c_usage), 32'd15);
      check("pre_reset_p_usage", 32'(p_usage), 32'd5);
      reset = 1;
      step();
      reset = 0;
      check("mid_reset_p_srdy", 32'(p_srdy), 32'd0);
      check("mid_reset_c_drdy", 32'(c_drdy), 32'd1);
      check("mid_reset_c_usage", 32'(c_usage), 32'd0);
      check("mid_reset_p_usage", 32'(p_usage), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         c_srdy   = 1'($urandom_range(0, 1));
         c_data   = W'($urandom);
         c_commit = ($urandom_range(0, 3) == 0);
         c_abort  = ($urandom_range(0, 15) == 0);
         p_drdy   = 1'($urandom_range(0, 1));
         p_commit = ($urandom_range(0, 3) == 0);
         p_abort  = ($urandom_range(0, 15) == 0);
         reset    = ($urandom_range(0, 499) == 0);
         step();
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
